// File: rtl/mips_state_sequencer_if.sv
// Bus between the MIPS datapath and its stage sequencer: decoded instruction
// fields and stall inputs one way, stage/retirement status the other.
interface mips_state_sequencer_if;
    logic [5:0]  opcode;
    logic [5:0]  func_code;
    logic [4:0]  rt_code;
    logic        waitrequest;
    logic        alu_busy;
    logic        pc_zero;
    logic [2:0]  state;
    logic        active;
    logic        instr_done;
    logic [31:0] instr_count;

    modport master (
        output opcode, func_code, rt_code, waitrequest, alu_busy, pc_zero,
        input  state, active, instr_done, instr_count
    );

    modport slave (
        input  opcode, func_code, rt_code, waitrequest, alu_busy, pc_zero,
        output state, active, instr_done, instr_count
    );
endinterface

// File: rtl/mips_state_sequencer.sv
// Multi-cycle MIPS stage sequencer: FETCH -> DECODE -> EXECUTE -> MEMORY ->
// (WRITE_BACK for loads) with stall handling, halt on PC==0 and retirement count.
module mips_state_sequencer (
    input  logic              clk,
    input  logic              reset,
    mips_state_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        FETCH_INSTR   = 3'b000,
        DECODE        = 3'b001,
        EXECUTE       = 3'b010,
        MEMORY_ACCESS = 3'b011,
        WRITE_BACK    = 3'b100,
        HALTED        = 3'b101
    } state_t;

    // Register holds raw bits so the unused codes 110/111 stay representable
    // and are steered back to FETCH_INSTR by the default arm below.
    logic [2:0]  state_q;
    state_t      state_d;
    logic        done_q;
    logic [31:0] count_q;
    logic        is_mem;
    logic        is_load;
    logic        retire;

    // R-type function and REGIMM selector do not alter the stage sequence.
    logic        unused_decode_fields;
    assign unused_decode_fields = ^{bus.func_code, bus.rt_code};

    always_comb begin
        is_mem  = 1'b0;
        is_load = 1'b0;
        case (bus.opcode)
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: begin
                is_mem  = 1'b1;
                is_load = 1'b1;
            end
            6'h28, 6'h29, 6'h2B: is_mem = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH_INSTR;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= retire;
            if (retire)
                count_q <= count_q + 32'd1;
        end
    end

    always_comb begin
        state_d = FETCH_INSTR;
        case (state_q)
            FETCH_INSTR: begin
                if (bus.pc_zero)
                    state_d = HALTED;
                else if (bus.waitrequest)
                    state_d = FETCH_INSTR;
                else
                    state_d = DECODE;
            end
            DECODE:  state_d = EXECUTE;
            EXECUTE: state_d = bus.alu_busy ? EXECUTE : MEMORY_ACCESS;
            MEMORY_ACCESS: begin
                if (!is_mem)
                    state_d = FETCH_INSTR;
                else if (bus.waitrequest)
                    state_d = MEMORY_ACCESS;
                else if (is_load)
                    state_d = WRITE_BACK;
                else
                    state_d = FETCH_INSTR;
            end
            WRITE_BACK: state_d = FETCH_INSTR;
            HALTED:     state_d = HALTED;
            default:    state_d = FETCH_INSTR;
        endcase
    end

    always_comb begin
        bus.active = (state_q != HALTED);
        retire     = ((state_q == MEMORY_ACCESS) || (state_q == WRITE_BACK))
                     && (state_d == FETCH_INSTR);
    end

    assign bus.state       = state_q;
    assign bus.instr_done  = done_q;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_mips_state_sequencer.sv
// Directed bench for mips_state_sequencer: per-cycle stimulus tables with
// hand-derived stage sequences, retirement pulses and counts.
module tb_mips_state_sequencer;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    mips_state_sequencer_if bus ();

    mips_state_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step;
        step;
        total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", bus.state); end
        total++; if (bus.instr_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", bus.instr_done); end
        total++; if (bus.instr_count !== 32'd0) begin bad++; $display("FAIL reset_count: got %0h want 0", bus.instr_count); end
        total++; if (bus.active !== 1'b1) begin bad++; $display("FAIL reset_active: got %0b want 1", bus.active); end
        reset = 1'b0;
    endtask

    task automatic test_addu;
        logic [2:0] es [5];
        logic       ed [5];
        es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bus.opcode = 6'h00; bus.func_code = 6'h21; bus.rt_code = 5'd0;
        for (int i = 0; i < 5; i++) begin
            bus.waitrequest = 1'b0; bus.alu_busy = 1'b0; bus.pc_zero = 1'b0;
            total++; if (bus.state !== es[i]) begin bad++; $display("FAIL addu_state[%0d]: got %0d want %0d", i, bus.state, es[i]); end
            total++; if (bus.instr_done !== ed[i]) begin bad++; $display("FAIL addu_done[%0d]: got %0b want %0b", i, bus.instr_done, ed[i]); end
            if (i < 4) step;
        end
        total++; if (bus.instr_count !== 32'd1) begin bad++; $display("FAIL addu_count: got %0h want 1", bus.instr_count); end
    endtask

    task automatic test_lw_stalls;
        logic [2:0] es [11];
        logic       wr [11];
        logic       ed [11];
        es = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
        wr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        ed = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bus.opcode = 6'h23; bus.func_code = 6'h00;
        for (int i = 0; i < 11; i++) begin
            bus.waitrequest = wr[i]; bus.alu_busy = 1'b0; bus.pc_zero = 1'b0;
            total++; if (bus.state !== es[i]) begin bad++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, bus.state, es[i]); end
            total++; if (bus.instr_done !== ed[i]) begin bad++; $display("FAIL lw_done[%0d]: got %0b want %0b", i, bus.instr_done, ed[i]); end
            if (i == 9) begin
                total++; if (bus.instr_count !== 32'd1) begin bad++; $display("FAIL lw_count_pre: got %0h want 1", bus.instr_count); end
            end
            if (i < 10) step;
        end
        total++; if (bus.instr_count !== 32'd2) begin bad++; $display("FAIL lw_count: got %0h want 2", bus.instr_count); end
    endtask

    task automatic test_div_busy;
        logic [2:0] es [10];
        logic       bz [10];
        logic       wr [10];
        logic       ed [10];
        es = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd0};
        bz = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        wr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ed = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bus.opcode = 6'h00; bus.func_code = 6'h1A;
        for (int i = 0; i < 10; i++) begin
            bus.waitrequest = wr[i]; bus.alu_busy = bz[i]; bus.pc_zero = 1'b0;
            total++; if (bus.state !== es[i]) begin bad++; $display("FAIL div_state[%0d]: got %0d want %0d", i, bus.state, es[i]); end
            total++; if (bus.instr_done !== ed[i]) begin bad++; $display("FAIL div_done[%0d]: got %0b want %0b", i, bus.instr_done, ed[i]); end
            if (i < 9) step;
        end
        total++; if (bus.instr_count !== 32'd3) begin bad++; $display("FAIL div_count: got %0h want 3", bus.instr_count); end
    endtask

    task automatic test_unknown_op(input logic [31:0] want_count);
        logic [2:0] es [5];
        logic       wr [5];
        logic       ed [5];
        es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        wr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        ed = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        bus.opcode = 6'h3F; bus.func_code = 6'h3F; bus.rt_code = 5'h1F;
        for (int i = 0; i < 5; i++) begin
            bus.waitrequest = wr[i]; bus.alu_busy = 1'b0; bus.pc_zero = 1'b0;
            total++; if (bus.state !== es[i]) begin bad++; $display("FAIL unk_state[%0d]: got %0d want %0d", i, bus.state, es[i]); end
            total++; if (bus.instr_done !== ed[i]) begin bad++; $display("FAIL unk_done[%0d]: got %0b want %0b", i, bus.instr_done, ed[i]); end
            if (i < 4) step;
        end
        total++; if (bus.instr_count !== want_count) begin bad++; $display("FAIL unk_count: got %0h want %0h", bus.instr_count, want_count); end
    endtask

    task automatic test_halt;
        bus.pc_zero = 1'b1; bus.waitrequest = 1'b1; bus.alu_busy = 1'b0;
        step;
        total++; if (bus.state !== 3'd5) begin bad++; $display("FAIL halt_state: got %0d want 5", bus.state); end
        total++; if (bus.active !== 1'b0) begin bad++; $display("FAIL halt_active: got %0b want 0", bus.active); end
        total++; if (bus.instr_done !== 1'b0) begin bad++; $display("FAIL halt_done: got %0b want 0", bus.instr_done); end
        for (int i = 0; i < 20; i++) begin
            bus.opcode      = 6'($urandom);
            bus.func_code   = 6'($urandom);
            bus.rt_code     = 5'($urandom);
            bus.waitrequest = 1'($urandom);
            bus.alu_busy    = 1'($urandom);
            bus.pc_zero     = 1'($urandom);
            step;
            total++; if (bus.state !== 3'd5) begin bad++; $display("FAIL halt_sticky[%0d]: got %0d want 5", i, bus.state); end
            total++; if (bus.instr_done !== 1'b0) begin bad++; $display("FAIL halt_sticky_done[%0d]: got %0b want 0", i, bus.instr_done); end
        end
        total++; if (bus.instr_count !== 32'd4) begin bad++; $display("FAIL halt_count: got %0h want 4", bus.instr_count); end
        reset = 1'b1; bus.pc_zero = 1'b1;
        step;
        reset = 1'b0; bus.pc_zero = 1'b0; bus.waitrequest = 1'b0; bus.alu_busy = 1'b0;
        total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL halt_reset_state: got %0d want 0", bus.state); end
        total++; if (bus.active !== 1'b1) begin bad++; $display("FAIL halt_reset_active: got %0b want 1", bus.active); end
        total++; if (bus.instr_count !== 32'd0) begin bad++; $display("FAIL halt_reset_count: got %0h want 0", bus.instr_count); end
    endtask

    task automatic test_wrap_sw;
        logic [2:0] es [6];
        logic       wr [6];
        logic       ed [6];
        es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd0};
        wr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        total++; if (bus.instr_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_preload: got %0h want ffffffff", bus.instr_count); end
        bus.opcode = 6'h2B; bus.func_code = 6'h00; bus.rt_code = 5'd0;
        for (int i = 0; i < 6; i++) begin
            bus.waitrequest = wr[i]; bus.alu_busy = 1'b0; bus.pc_zero = 1'b0;
            total++; if (bus.state !== es[i]) begin bad++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, bus.state, es[i]); end
            total++; if (bus.instr_done !== ed[i]) begin bad++; $display("FAIL sw_done[%0d]: got %0b want %0b", i, bus.instr_done, ed[i]); end
            if (i < 5) step;
        end
        total++; if (bus.instr_count !== 32'd0) begin bad++; $display("FAIL wrap_count: got %0h want 0", bus.instr_count); end
    endtask

    task automatic test_reset_mid_stall;
        logic [2:0] es [5];
        logic       wr [5];
        es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3};
        wr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bus.opcode = 6'h20;
        for (int i = 0; i < 5; i++) begin
            bus.waitrequest = wr[i]; bus.alu_busy = 1'b0; bus.pc_zero = 1'b0;
            total++; if (bus.state !== es[i]) begin bad++; $display("FAIL lb_state[%0d]: got %0d want %0d", i, bus.state, es[i]); end
            if (i < 4) step;
        end
        total++; if (bus.instr_count !== 32'd1) begin bad++; $display("FAIL lb_count_pre: got %0h want 1", bus.instr_count); end
        reset = 1'b1;
        step;
        reset = 1'b0; bus.waitrequest = 1'b0;
        total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL lb_reset_state: got %0d want 0", bus.state); end
        total++; if (bus.instr_done !== 1'b0) begin bad++; $display("FAIL lb_reset_done: got %0b want 0", bus.instr_done); end
        total++; if (bus.instr_count !== 32'd0) begin bad++; $display("FAIL lb_reset_count: got %0h want 0", bus.instr_count); end
    endtask

    task automatic test_illegal_state;
        bus.pc_zero = 1'b1; bus.waitrequest = 1'b1;
        force dut.state_q = 3'b111;
        #1;
        total++; if (bus.state !== 3'd7) begin bad++; $display("FAIL illegal_forced: got %0d want 7", bus.state); end
        total++; if (bus.active !== 1'b1) begin bad++; $display("FAIL illegal_active: got %0b want 1", bus.active); end
        release dut.state_q;
        step;
        total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL illegal_recover: got %0d want 0", bus.state); end
        total++; if (bus.instr_done !== 1'b0) begin bad++; $display("FAIL illegal_done: got %0b want 0", bus.instr_done); end
        bus.pc_zero = 1'b0; bus.waitrequest = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.opcode = '0; bus.func_code = '0; bus.rt_code = '0;
        bus.waitrequest = 1'b0; bus.alu_busy = 1'b0; bus.pc_zero = 1'b0;
        test_reset;
        test_addu;
        test_lw_stalls;
        test_div_busy;
        test_unknown_op(32'd4);
        test_halt;
        test_wrap_sw;
        test_unknown_op(32'd1);
        test_reset_mid_stall;
        test_illegal_state;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
